// File: rtl/pipe_adder16_if.sv
// Handshake and operand/result bundle for pipe_adder16.
// master = producer/consumer side, slave = the adder itself.
interface pipe_adder16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;
  logic        ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/pipe_adder16.sv
// 16-bit adder built from four pipelined 4-bit ripple slices plus an output register.
// Optional macro PIPE_ADDER16_SUB_EN enables subtraction through the sub input.
module pipe_adder16 (
  input  logic           clk,
  input  logic           reset,
  pipe_adder16_if.slave  bus
);

  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;

  // One 4-bit ripple-carry slice: {carry_out, sum}.
  function automatic logic [NW:0] rca4(input logic [NW-1:0] x,
                                       input logic [NW-1:0] y,
                                       input logic          cin);
    logic          c;
    logic [NW:0]   r;
    c = cin;
    r = '0;
    for (int i = 0; i < int'(NW); i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[NW] = c;
    return r;
  endfunction

  logic [W-1:0] w_b_eff;
  logic         w_cin;
  logic         w_adv;
  logic [NW:0]  w_n0;
  logic [NW:0]  w_n1;
  logic [NW:0]  w_n2;
  logic [NW:0]  w_n3;

  // Stage k holds the low 4(k+1) sum bits plus the still-unprocessed operand nibbles.
  logic         r_s0_v, r_s0_c, r_s0_a15, r_s0_b15;
  logic [3:0]   r_s0_sum;
  logic [11:0]  r_s0_a, r_s0_b;

  logic         r_s1_v, r_s1_c, r_s1_a15, r_s1_b15;
  logic [7:0]   r_s1_sum;
  logic [7:0]   r_s1_a, r_s1_b;

  logic         r_s2_v, r_s2_c, r_s2_a15, r_s2_b15;
  logic [11:0]  r_s2_sum;
  logic [3:0]   r_s2_a, r_s2_b;

  logic         r_s3_v, r_s3_c, r_s3_a15, r_s3_b15;
  logic [15:0]  r_s3_sum;

  logic         r_out_valid;
  logic [15:0]  r_out_s;
  logic         r_out_co;
  logic         r_out_ovf;

`ifdef PIPE_ADDER16_SUB_EN
  assign w_b_eff = bus.sub ? ~bus.b : bus.b;
  assign w_cin   = bus.sub ? 1'b1   : bus.ci;
`else
  // sub stays on the port but has no function in this build.
  logic w_unused_sub;
  assign w_unused_sub = bus.sub;
  assign w_b_eff      = bus.b;
  assign w_cin        = bus.ci;
`endif

  // The whole pipe moves as one unit whenever the output slot is free or being drained.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  assign w_n0 = rca4(bus.a[3:0],   w_b_eff[3:0], w_cin);
  assign w_n1 = rca4(r_s0_a[3:0],  r_s0_b[3:0],  r_s0_c);
  assign w_n2 = rca4(r_s1_a[3:0],  r_s1_b[3:0],  r_s1_c);
  assign w_n3 = rca4(r_s2_a,       r_s2_b,       r_s2_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_v   <= 1'b0;
      r_s0_c   <= 1'b0;
      r_s0_a15 <= 1'b0;
      r_s0_b15 <= 1'b0;
      r_s0_sum <= '0;
      r_s0_a   <= '0;
      r_s0_b   <= '0;
      r_s1_v   <= 1'b0;
      r_s1_c   <= 1'b0;
      r_s1_a15 <= 1'b0;
      r_s1_b15 <= 1'b0;
      r_s1_sum <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s2_v   <= 1'b0;
      r_s2_c   <= 1'b0;
      r_s2_a15 <= 1'b0;
      r_s2_b15 <= 1'b0;
      r_s2_sum <= '0;
      r_s2_a   <= '0;
      r_s2_b   <= '0;
      r_s3_v   <= 1'b0;
      r_s3_c   <= 1'b0;
      r_s3_a15 <= 1'b0;
      r_s3_b15 <= 1'b0;
      r_s3_sum <= '0;
    end else if (w_adv) begin
      r_s0_v   <= bus.in_valid;
      r_s0_c   <= w_n0[NW];
      r_s0_a15 <= bus.a[15];
      r_s0_b15 <= w_b_eff[15];
      r_s0_sum <= w_n0[NW-1:0];
      r_s0_a   <= bus.a[15:4];
      r_s0_b   <= w_b_eff[15:4];

      r_s1_v   <= r_s0_v;
      r_s1_c   <= w_n1[NW];
      r_s1_a15 <= r_s0_a15;
      r_s1_b15 <= r_s0_b15;
      r_s1_sum <= {w_n1[NW-1:0], r_s0_sum};
      r_s1_a   <= r_s0_a[11:4];
      r_s1_b   <= r_s0_b[11:4];

      r_s2_v   <= r_s1_v;
      r_s2_c   <= w_n2[NW];
      r_s2_a15 <= r_s1_a15;
      r_s2_b15 <= r_s1_b15;
      r_s2_sum <= {w_n2[NW-1:0], r_s1_sum};
      r_s2_a   <= r_s1_a[7:4];
      r_s2_b   <= r_s1_b[7:4];

      r_s3_v   <= r_s2_v;
      r_s3_c   <= w_n3[NW];
      r_s3_a15 <= r_s2_a15;
      r_s3_b15 <= r_s2_b15;
      r_s3_sum <= {w_n3[NW-1:0], r_s2_sum};
    end
  end

  // Output register; overflow is resolved here from the carried operand sign bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_co    <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s3_v;
      r_out_s     <= r_s3_sum;
      r_out_co    <= r_s3_c;
      r_out_ovf   <= (r_s3_a15 == r_s3_b15) && (r_s3_sum[15] != r_s3_a15);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_out_s;
  assign bus.co        = r_out_co;
  assign bus.ovf       = r_out_ovf;

endmodule

// File: tb/tb_pipe_adder16.sv
// Directed bench for pipe_adder16: latency, streaming, stall, bubbles and reset flush.
// Results are tracked through a queue of hand-computed expected values.
module tb_pipe_adder16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    int          id;
  } exp_t;

  localparam int NV = 10;

  logic clk;
  logic reset;
  pipe_adder16_if bus ();

  pipe_adder16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t vecs [NV];
  exp_t exp_q [$];
  int   cur_idx  = 0;
  int   n_total  = 0;
  int   n_bad    = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  int   run_len  = 0;
  int   max_run  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i);
    cur_idx      = i;
    bus.a        = vecs[i].a;
    bus.b        = vecs[i].b;
    bus.ci       = vecs[i].ci;
    bus.sub      = vecs[i].sub;
    bus.in_valid = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Score the handshakes that will fire on the coming edge, then advance one cycle.
  task automatic step();
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.s), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("s[%0d]", e.id),   32'(bus.s),   32'(e.s));
          chk($sformatf("co[%0d]", e.id),  32'(bus.co),  32'(e.co));
          chk($sformatf("ovf[%0d]", e.id), 32'(bus.ovf), 32'(e.ovf));
          n_popped++;
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        e.s   = vecs[cur_idx].s;
        e.co  = vecs[cur_idx].co;
        e.ovf = vecs[cur_idx].ovf;
        e.id  = cur_idx;
        exp_q.push_back(e);
        n_pushed++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  endtask

  task automatic send(input int i);
    int guard;
    drive(i);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (bus.in_ready !== 1'b1) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    else step();
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && exp_q.size() > 0; k++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
`ifdef PIPE_ADDER16_SUB_EN
    vecs[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
    vecs[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0};
`endif

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_s",         32'(bus.s),         32'd0);
    chk("rst_co",        32'(bus.co),        32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Single operation: visible exactly four edges after acceptance.
    drive(0);
    step();
    idle();
    step();
    step();
    step();
    chk("lat_edge3_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_edge4_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_s",   32'(bus.s),   32'h5555);
    chk("lat_co",  32'(bus.co),  32'd0);
    chk("lat_ovf", 32'(bus.ovf), 32'd0);
    step();

    // Back-to-back stream with the consumer always ready.
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < NV; i++) send(i);
    idle();
    drain();
    chk("stream_consecutive", 32'(max_run), 32'(NV));
    chk("stream_count", 32'(n_popped), 32'(n_pushed));

    // Fill with a bubble, then stall the consumer for three cycles.
    for (int j = 0; j < 6; j++) begin
      send(j);
      if (j == 2) begin
        idle();
        step();
      end
    end
    chk("stall_pre_valid", 32'(bus.out_valid), 32'd1);
    drive(6);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
      chk("stall_valid",    32'(bus.out_valid), 32'd1);
      if (exp_q.size() > 0) begin
        chk("stall_s",   32'(bus.s),   32'(exp_q[0].s));
        chk("stall_co",  32'(bus.co),  32'(exp_q[0].co));
        chk("stall_ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
      end else begin
        chk("stall_queue", 32'(exp_q.size()), 32'd1);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 6; i < NV; i++) send(i);
    idle();
    drain();
    chk("stall_count", 32'(n_popped), 32'(n_pushed));

    // Reset with three operations in flight: none may emerge.
    send(0);
    send(1);
    send(2);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_s",         32'(bus.s),         32'd0);
    chk("flush_co",        32'(bus.co),        32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("flush_idle_%0d", k), 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_adder16.md
PIPE_ADDER16 -- requirements
Module: pipe_adder16

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits, pipeline depth fixed at 4 stages.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set on a, b, sub, ci is valid this cycle.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 a  input  16  operand A.
REQ-007 b  input  16  operand B.
REQ-008 ci  input  1  carry-in; ignored when subtraction is selected.
REQ-009 sub  input  1  1 = A minus B, 0 = A plus B (see Configuration).
REQ-010 out_valid  output  1  s, co, ovf hold a completed result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 s  output  16  sum/difference.
REQ-013 co  output  1  carry-out of bit 15.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL have four stages; stage k (k = 0..3) adds bits [4k+3:4k] using one 4-bit ripple-carry slice fed by the carry registered from stage k-1.
REQ-016 Each stage register SHALL carry: a valid bit, the completed low sum nibbles, the remaining unprocessed operand nibbles (skewed), the inter-stage carry, and bit 15 of the effective operands needed for ovf.
REQ-017 Global advance: adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-018 When adv = 1, every stage SHALL shift forward one position on the clock edge; stage 0 loads valid = in_valid.
REQ-019 When adv = 0, all stage registers including outputs SHALL hold their values.
REQ-020 Latency: an operand set accepted at edge N SHALL appear with out_valid = 1 after edge N+4, provided adv stays 1.
REQ-021 Throughput: one result per cycle when out_ready stays high; bubbles (in_valid = 0) SHALL propagate as invalid slots and SHALL NOT block later data.
REQ-022 Effective operands: B' = sub ? ~b : b, carry-in = sub ? 1 : ci.
REQ-023 s SHALL equal (a + B' + carry-in) mod 2^16, and co SHALL equal bit 16 of that sum.
REQ-024 ovf SHALL equal (a[15] == B'[15]) && (s[15] != a[15]).
REQ-025 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-026 A result held under stall (out_valid = 1, out_ready = 0) SHALL keep s, co and ovf stable until consumed.
REQ-027 Simultaneous consume and accept (out_valid = out_ready = in_valid = 1) SHALL shift the pipe in the same cycle with no bubble inserted.

Reset
REQ-028 While reset = 1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and s, co and ovf SHALL clear to 0.
REQ-029 Reset SHALL take priority over adv; in-flight operations at reset SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro PIPE_ADDER16_SUB_EN: when defined, sub behaves as specified in REQ-022.
REQ-032 When PIPE_ADDER16_SUB_EN is not defined, the sub port SHALL remain present but be ignored, with B' = b and carry-in = ci; no inversion logic SHALL be synthesized.

Verification
REQ-033 After reset, a=0x1234, b=0x4321, ci=0, sub=0, out_ready=1 -> four edges later out_valid=1, s=0x5555, co=0, ovf=0.
REQ-034 a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
REQ-035 With SUB_EN defined, a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1.
REQ-036 Stream 8 back-to-back operands with out_ready=1 -> 8 consecutive out_valid cycles in order; then hold out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, no loss after release.
REQ-037 Assert reset with 3 operations in flight -> next cycle out_valid=0 and s=0; none of those 3 results ever appear.
